// File: rtl/addsub_fixed_pipe.sv
// Two-stage sign-magnitude add/sub with valid/ready flow control, one result per cycle.
// Build option: define ADDSUB_SATURATE_EN to saturate overflowing magnitudes instead of wrapping.
`timescale 1ns/1ps
module addsub_fixed_pipe #(
  parameter int N     = 16,
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [N*LANES-1:0] a,
  input  logic [N*LANES-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*LANES-1:0] y,
  output logic [LANES-1:0]   ovf
);
  localparam int M = N - 1;

  logic s1_valid_q;
  logic out_valid_q;
  logic s2_en;
  logic s1_en;
  logic accept;

  // The output register frees up when empty or being popped; stage 1 can then always move forward.
  assign s2_en     = !out_valid_q || out_ready;
  assign s1_en     = !s1_valid_q || s2_en;
  assign in_ready  = s1_en;
  assign accept    = in_valid && s1_en;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (s1_en) s1_valid_q  <= in_valid;
      if (s2_en) out_valid_q <= s1_valid_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [M-1:0] a_mag, b_mag, l_d, s_d, l_q, s_q, mag_d;
      logic         a_sign, b_sign, b_eff, same_d, sign_d, same_q, sign_q;
      logic [N-1:0] sum;
      logic         carry;
      logic [N-1:0] y_d, y_q;
      logic         ovf_d, ovf_q;

      // A -0 operand is folded to +0 before the sign logic sees it.
      always_comb begin
        a_mag  = a[gi*N +: M];
        b_mag  = b[gi*N +: M];
        a_sign = a[gi*N + M] & (|a_mag);
        b_sign = b[gi*N + M] & (|b_mag);
        b_eff  = b_sign ^ op;
        same_d = (a_sign == b_eff);
        l_d    = (a_mag >= b_mag) ? a_mag : b_mag;
        s_d    = (a_mag >= b_mag) ? b_mag : a_mag;
        if (same_d)               sign_d = a_sign;
        else if (a_mag > b_mag)   sign_d = a_sign;
        else if (b_mag > a_mag)   sign_d = b_eff;
        else                      sign_d = 1'b0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          l_q    <= '0;
          s_q    <= '0;
          same_q <= 1'b0;
          sign_q <= 1'b0;
        end else if (accept) begin
          l_q    <= l_d;
          s_q    <= s_d;
          same_q <= same_d;
          sign_q <= sign_d;
        end
      end

      always_comb begin
        sum   = {1'b0, l_q} + {1'b0, s_q};
        carry = sum[M];
        ovf_d = same_q & carry;
        if (same_q) begin
`ifdef ADDSUB_SATURATE_EN
          mag_d = carry ? '1 : sum[M-1:0];
`else
          mag_d = sum[M-1:0];
`endif
        end else begin
          mag_d = l_q - s_q;
        end
        y_d = {sign_q & (|mag_d), mag_d};
      end

      // Load only real data so y/ovf stay frozen while the consumer stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q   <= '0;
          ovf_q <= 1'b0;
        end else if (s2_en && s1_valid_q) begin
          y_q   <= y_d;
          ovf_q <= ovf_d;
        end
      end

      assign y[gi*N +: N] = y_q;
      assign ovf[gi]      = ovf_q;
    end
  endgenerate
endmodule

// File: tb/tb_addsub_fixed_pipe.sv
// Directed bench for addsub_fixed_pipe: an N=8 single-lane instance and an N=8 four-lane instance.
`timescale 1ns/1ps
module tb_addsub_fixed_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [7:0]  a, b, y;
  logic [0:0]  ovf;

  logic        in_valid4, in_ready4, op4, out_valid4, out_ready4;
  logic [31:0] a4, b4, y4;
  logic [3:0]  ovf4;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef ADDSUB_SATURATE_EN
  localparam logic [7:0] EXP_P150 = 8'h7F;
  localparam logic [7:0] EXP_N150 = 8'hFF;
`else
  localparam logic [7:0] EXP_P150 = 8'h16;
  localparam logic [7:0] EXP_N150 = 8'h96;
`endif

  always #5 clk = ~clk;

  addsub_fixed_pipe #(.N(8), .LANES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  addsub_fixed_pipe #(.N(8), .LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .y(y4), .ovf(ovf4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run1(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic top, input logic [7:0] ey, input logic eovf);
    int lat;
    @(negedge clk);
    out_ready = 1'b1; a = ta; b = tb_v; op = top; in_valid = 1'b1;
    #1 check_eq({tag, "_inrdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd2);
    check_eq({tag, "_y"}, 32'(y), 32'(ey));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    $display("[TB] txn %s a=%02h b=%02h op=%0d -> y=%02h ovf=%0b", tag, ta, tb_v, top, y, ovf);
    @(negedge clk);
    #1 check_eq({tag, "_1cyc"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run4(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                      input logic top, input logic [31:0] ey, input logic [3:0] eovf);
    int waitc;
    @(negedge clk);
    out_ready4 = 1'b1; a4 = ta; b4 = tb_v; op4 = top; in_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    waitc = 0;
    while (!out_valid4 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check_eq({tag, "_valid"}, 32'(out_valid4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_l%0d_y", tag, i), 32'(y4[i*8 +: 8]), 32'(ey[i*8 +: 8]));
      check_eq($sformatf("%s_l%0d_ovf", tag, i), 32'(ovf4[i]), 32'(eovf[i]));
    end
    $display("[TB] txn %s a=%08h b=%08h op=%0d -> y=%08h ovf=%04b", tag, ta, tb_v, top, y4, ovf4);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, popped, stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; op4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_y", 32'(y), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    #1 check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    run1("add_5_3",    8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    run1("add_3_m5",   8'h03, 8'h85, 1'b0, 8'h82, 1'b0);
    run1("sub_3_m5",   8'h03, 8'h85, 1'b1, 8'h08, 1'b0);
    run1("sub_5_5",    8'h05, 8'h05, 1'b1, 8'h00, 1'b0);
    run1("add_m0_0",   8'h80, 8'h00, 1'b0, 8'h00, 1'b0);
    run1("ovf_pos",    8'h64, 8'h32, 1'b0, EXP_P150, 1'b1);
    run1("ovf_neg",    8'hE4, 8'hB2, 1'b0, EXP_N150, 1'b1);
    run1("sub_1_2",    8'h01, 8'h02, 1'b1, 8'h81, 1'b0);

    // Backpressure: four back-to-back pushes with the consumer stalled for the first cycles.
    pushed = 0; popped = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (pushed < 4);
      a = 8'(pushed + 1); b = 8'h01; op = 1'b0;
      #1;
      if (c == 2) check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      if (c >= 2 && c <= 4) begin
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_y_hold", 32'(y), 32'h02);
      end
      if (out_valid && out_ready) begin
        check_eq($sformatf("stream_y%0d", popped), 32'(y), 32'(popped + 2));
        $display("[TB] txn stream pop %0d y=%02h", popped, y);
        popped++;
      end
      if (in_valid && in_ready) pushed++;
    end
    in_valid = 1'b0;
    check_eq("stream_count", 32'(popped), 32'd4);

    // Asynchronous reset with two transactions in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    a = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_eq("rst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_async_valid", 32'(out_valid), 32'd0);
    check_eq("rst_async_y", 32'(y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rst_post_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_eq("rst_no_stale", 32'(stale), 32'd0);
    $display("[TB] txn reset_flush stale=%0d", stale);

    run4("lanes_add", 32'h80_64_85_05, 32'h00_32_03_03, 1'b0,
         {8'h00, EXP_P150, 8'h82, 8'h08}, 4'b0100);
    run4("lanes_sub", 32'h01_E4_03_05, 32'h02_32_85_05, 1'b1,
         {8'h81, EXP_N150, 8'h08, 8'h00}, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
